// File: rtl/ram_load_ctrl_if.sv
// Stream-in and RAM-write bus of the RAM load sequencer.
// Handshake: a word transfers on a rising clk edge where in_valid & in_ready are both high.
interface ram_load_ctrl_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic [15:0] wren;
  logic [5:0]  wr_addr;

  modport master (
    output in_data, in_valid,
    input  in_ready, data, wren, wr_addr
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, data, wren, wr_addr
  );
endinterface

// File: rtl/ram_load_ctrl.sv
// Parses framed stream words and steers fixed-length payload blocks into one of 16 RAMs.
// Optional macro LOAD_TIMEOUT_EN aborts a block that stalls for TMO_CYCLES idle cycles.
module ram_load_ctrl #(
  parameter int CA_WORDS   = 32,
  parameter int MSG_WORDS  = 47,
  parameter int TMO_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_load_ctrl_if.slave   bus,
  output logic [9:0]       delay_ca0,
  output logic [9:0]       delay_ca1,
  output logic [9:0]       delay_ca2,
  output logic [9:0]       delay_ca3,
  output logic [9:0]       delay_ca4,
  output logic [9:0]       delay_ca5,
  output logic [9:0]       delay_ca6,
  output logic [9:0]       delay_ca7,
  output logic             busy,
  output logic             done,
  output logic [3:0]       done_id,
  output logic             err,
  output logic             state_dbg
);
  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [5:0] CA_LAST  = 6'(CA_WORDS - 1);
  localparam logic [5:0] MSG_LAST = 6'(MSG_WORDS - 1);

  state_t      state_q, state_n;
  logic [5:0]  cnt_q, cnt_n;
  logic        typ_q, typ_n;
  logic [2:0]  ch_q, ch_n;
  logic        rdy_q;
  logic [31:0] data_q, data_n;
  logic [15:0] wren_q, wren_n;
  logic [5:0]  addr_q, addr_n;
  logic        done_q, done_n;
  logic [3:0]  done_id_q, done_id_n;
  logic        err_q, err_n;
  logic [9:0]  delay_q [8];
  logic [9:0]  delay_n [8];
  logic        accept;
  logic [5:0]  last_idx;

`ifdef LOAD_TIMEOUT_EN
  logic [11:0] tmo_q, tmo_n;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYCLES != 0);
`endif

  assign accept   = bus.in_valid & rdy_q;
  assign last_idx = typ_q ? MSG_LAST : CA_LAST;

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    typ_n     = typ_q;
    ch_n      = ch_q;
    data_n    = data_q;
    addr_n    = addr_q;
    wren_n    = 16'h0000;
    done_n    = 1'b0;
    done_id_n = done_id_q;
    err_n     = 1'b0;
    delay_n   = delay_q;
`ifdef LOAD_TIMEOUT_EN
    tmo_n     = 12'd0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_data[31:24] != 8'hA5 || bus.in_data[23:20] > 4'd2) begin
            err_n = 1'b1;
          end else if (bus.in_data[23:20] == 4'd2) begin
            delay_n[bus.in_data[18:16]] = bus.in_data[9:0];
          end else begin
            typ_n   = bus.in_data[20];
            ch_n    = bus.in_data[18:16];
            cnt_n   = 6'd0;
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        // Every word here is payload, even one that looks like a header.
        if (accept) begin
          data_n = bus.in_data;
          wren_n = 16'h0001 << {typ_q, ch_q};
          addr_n = cnt_q;
          cnt_n  = cnt_q + 6'd1;
          if (cnt_q == last_idx) begin
            done_n    = 1'b1;
            done_id_n = {typ_q, ch_q};
            state_n   = IDLE;
          end
        end
`ifdef LOAD_TIMEOUT_EN
        else if (tmo_q == 12'(TMO_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo_q + 12'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      typ_q     <= 1'b0;
      ch_q      <= 3'd0;
      rdy_q     <= 1'b0;
      data_q    <= 32'd0;
      wren_q    <= 16'h0000;
      addr_q    <= 6'd0;
      done_q    <= 1'b0;
      done_id_q <= 4'd0;
      err_q     <= 1'b0;
      for (int i = 0; i < 8; i++) delay_q[i] <= 10'd0;
`ifdef LOAD_TIMEOUT_EN
      tmo_q     <= 12'd0;
`endif
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      typ_q     <= typ_n;
      ch_q      <= ch_n;
      rdy_q     <= 1'b1;
      data_q    <= data_n;
      wren_q    <= wren_n;
      addr_q    <= addr_n;
      done_q    <= done_n;
      done_id_q <= done_id_n;
      err_q     <= err_n;
      delay_q   <= delay_n;
`ifdef LOAD_TIMEOUT_EN
      tmo_q     <= tmo_n;
`endif
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.data     = data_q;
  assign bus.wren     = wren_q;
  assign bus.wr_addr  = addr_q;
  assign busy         = (state_q == LOAD);
  assign state_dbg    = state_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign err          = err_q;
  assign delay_ca0    = delay_q[0];
  assign delay_ca1    = delay_q[1];
  assign delay_ca2    = delay_q[2];
  assign delay_ca3    = delay_q[3];
  assign delay_ca4    = delay_q[4];
  assign delay_ca5    = delay_q[5];
  assign delay_ca6    = delay_q[6];
  assign delay_ca7    = delay_q[7];
endmodule

// File: tb/tb_ram_load_ctrl.sv
// Scoreboard bench for ram_load_ctrl: a header/payload model predicts every RAM write,
// done pulse, error pulse and delay register.
module tb_ram_load_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ram_load_ctrl_if bus();
  logic [9:0] delay_ca [8];
  logic       busy, done, err, state_dbg;
  logic [3:0] done_id;

  int n_tests = 0;
  int n_fail  = 0;

  // record: {done, done_id, wren, wr_addr, data}
  logic [58:0] exp_q[$];
  logic [9:0]  exp_delay [8];
  int          exp_err  = 0;
  int          err_seen = 0;
  bit          m_load   = 0;
  bit          m_typ    = 0;
  logic [2:0]  m_ch     = 3'd0;
  int          m_cnt    = 0;

  ram_load_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .delay_ca0 (delay_ca[0]),
    .delay_ca1 (delay_ca[1]),
    .delay_ca2 (delay_ca[2]),
    .delay_ca3 (delay_ca[3]),
    .delay_ca4 (delay_ca[4]),
    .delay_ca5 (delay_ca[5]),
    .delay_ca6 (delay_ca[6]),
    .delay_ca7 (delay_ca[7]),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one word for one cycle; the model predicts its effect.
  task automatic send(input logic [31:0] w);
    int last;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    if (!m_load) begin
      if (w[31:24] != 8'hA5 || w[23:20] > 4'd2) exp_err++;
      else if (w[23:20] == 4'd2) exp_delay[w[18:16]] = w[9:0];
      else begin
        m_load = 1; m_typ = w[20]; m_ch = w[18:16]; m_cnt = 0;
      end
    end else begin
      last = m_typ ? 46 : 31;
      exp_q.push_back({(m_cnt == last), (m_cnt == last) ? {m_typ, m_ch} : 4'h0,
                       16'h0001 << {m_typ, m_ch}, 6'(m_cnt), w});
      if (m_cnt == last) m_load = 0;
      m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_delays(input string tag);
    for (int i = 0; i < 8; i++) check(tag, {54'd0, delay_ca[i]}, {54'd0, exp_delay[i]});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_seen++;
      if (bus.wren != 16'h0 || done) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr", {5'd0, done, done_id, bus.wren, bus.wr_addr, bus.data}, 64'd0);
        end else begin
          check("wr_txn", {5'd0, done, done ? done_id : 4'h0, bus.wren, bus.wr_addr, bus.data},
                {5'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    bus.in_data  = 32'd0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) exp_delay[i] = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_outs", {bus.data, bus.wren, bus.wr_addr, busy, done, err, done_id},
          64'd0);
    check_delays("rst_delay");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("in_ready_up", {63'd0, bus.in_ready}, 64'd1);

    // C/A ch0, payload 0..31
    send(32'hA500_0000);
    for (int i = 0; i < 32; i++) begin
      send(32'(i));
      if (i == 15) check("busy_mid", {63'd0, busy}, 64'd1);
    end
    check("busy_after_ca", {63'd0, busy}, 64'd0);

    // MSG ch5 with in_valid toggling; header back-to-back not required here
    send(32'hA515_0000);
    for (int i = 0; i < 47; i++) begin
      send($urandom);
      idle(1);
    end
    check("busy_after_msg", {63'd0, busy}, 64'd0);

    // delay frame
    send(32'hA523_03FE);
    idle(1);
    check_delays("delay3");

    // rejected headers, then a back-to-back valid block whose payload mimics headers
    send(32'h5A00_0000);
    send(32'hA530_0000);
    idle(2);
    check("err_count", 64'(err_seen), 64'(exp_err));
    check("err_idle", {63'd0, busy}, 64'd0);
    send(32'hA501_0000);
    for (int i = 0; i < 32; i++) send((i % 2) ? 32'hA523_0001 : $urandom);
    send(32'hA527_03FF);
    send(32'hA516_0000);
    for (int i = 0; i < 47; i++) send($urandom);
    idle(1);
    check_delays("delay7");
    check("err_count2", 64'(err_seen), 64'(exp_err));

    // reset in the middle of a C/A ch7 block
    send(32'hA507_0000);
    for (int i = 0; i <= 10; i++) send($urandom);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_load = 0;
    for (int i = 0; i < 8; i++) exp_delay[i] = 10'd0;
    #1;
    check("midrst_outs", {bus.data, bus.wren, bus.wr_addr, busy, done, err, done_id}, 64'd0);
    check("midrst_ready", {63'd0, bus.in_ready}, 64'd0);
    check_delays("midrst_delay");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    send(32'hA517_0000);
    for (int i = 0; i < 47; i++) send($urandom);
    idle(1);

    // stall inside a C/A ch2 block
    send(32'hA502_0000);
    for (int i = 0; i < 6; i++) send($urandom);
`ifdef LOAD_TIMEOUT_EN
    idle(4100);
    exp_err++;
    m_load = 0;
    check("tmo_err", 64'(err_seen), 64'(exp_err));
    check("tmo_busy", {63'd0, busy}, 64'd0);
`else
    idle(10000);
    check("stall_busy", {63'd0, busy}, 64'd1);
    for (int i = 6; i < 32; i++) send($urandom);
    idle(1);
    check("stall_done_busy", {63'd0, busy}, 64'd0);
`endif
    idle(4);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("err_final", 64'(err_seen), 64'(exp_err));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_load_ctrl.md
# ram_load_ctrl

Load sequencer between the USB3 receive word stream and the 8-channel C/A-code / navigation-message RAM bank. It parses framed 32-bit words and steers payload into exactly one of 16 RAMs via a one-hot write enable with a per-block write address. It also latches per-channel C/A code-phase delays from delay frames. The block enforces fixed block lengths so a partial load can never leave a RAM misaligned.

## Interface
Parameters:
- CA_WORDS, 32, payload words per C/A-code block
- MSG_WORDS, 47, payload words per message block
- TMO_CYCLES, 4096, idle-cycle limit mid-block (used only with timeout compiled in)

Ports:
- clk  in  1  system clock (USB3 word clock domain)
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  32  incoming stream word
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  block accepts word when in_valid & in_ready
- data  out  32  registered RAM write data
- wren  out  16  one-hot write enable; [7:0] C/A RAM ch0..7, [15:8] message RAM ch0..7
- wr_addr  out  6  word index within current block
- delay_ca0 .. delay_ca7  out  10 each  code-phase delay per channel
- busy  out  1  high while a block load is in progress
- done  out  1  one-cycle pulse after last payload word written
- done_id  out  4  {type[0], channel[2:0]} of the completed block, valid with done
- err  out  1  one-cycle pulse on rejected header or aborted block

## Operation
- Header word: [31:24] sync = 8'hA5; [23:20] type (0 = C/A, 1 = MSG, 2 = DELAY); [18:16] channel; [9:0] delay value (type 2 only). Other bits ignored.
- FSM states: IDLE, LOAD.
- IDLE: on accepted word, if sync ≠ A5 or type > 2 → err pulse, stay IDLE. Type 2 → delay_caN ← [9:0], stay IDLE, no wren. Type 0/1 → latch type/channel, clear word counter, go LOAD.
- LOAD: each accepted word → data ← in_data, wren ← one-hot bit (type*8 + channel), wr_addr ← word counter, counter +1. On word CA_WORDS-1 (type 0) or MSG_WORDS-1 (type 1) → done pulse with done_id, return to IDLE. Words in LOAD are payload even if they match the sync pattern.
- in_ready = 1 whenever out of reset (IDLE and LOAD); 0 during reset.
- busy = (state == LOAD).
- Word counter 6 bits, range 0..MSG_WORDS-1; never wraps inside a block.
- Delays have no range check beyond 10 bits; values ≥ 1023 pass through unchanged.

## Timing
- Reset values: in_ready 0, data 0, wren 0, wr_addr 0, delay_ca0..7 0, busy 0, done 0, done_id 0, err 0, state IDLE.
- Payload word accepted at cycle n → data/wren/wr_addr valid cycle n+1, for exactly one cycle; wren 0 otherwise.
- Delay header accepted at n → delay_caN updated at n+1.
- done asserted in cycle n+1 together with the last wren; busy low from n+1.
- err asserted the cycle after the offending header is accepted.
- Header may immediately follow the last payload word (back-to-back, no gap cycle).
- in_valid low in LOAD: no write, counter holds, state holds.
- rst_n asserted mid-block: all outputs to reset values immediately, delays cleared, partial block discarded; no done.

## Configuration
- LOAD_TIMEOUT_EN defined: 12-bit idle counter runs in LOAD, cleared on each accepted word; reaching TMO_CYCLES consecutive cycles without in_valid → err pulse, return IDLE, no done, wren stays 0. Undefined: LOAD waits indefinitely; no timeout counter present.

## Test plan
- Header 32'hA5_00_0000 (C/A ch0) + 32 words 0..31 → wren=16'h0001 for 32 cycles, wr_addr 0..31, done once with done_id 4'h0, busy low after.
- Header 32'hA5_15_0000 (MSG ch5) + 47 words, in_valid toggled every other cycle → wren=16'h2000 on exactly 47 cycles, wr_addr 0..46, done_id 4'hD.
- Header 32'hA5_23_03FE → delay_ca3 = 10'h3FE next cycle, other delays 0, wren never asserted.
- Header 32'h5A_00_0000 and 32'hA5_30_0000 → err pulse each, state IDLE, no wren; following valid header processed normally.
- C/A ch7 load, rst_n low after word 10 → all outputs to reset values immediately; after release, fresh MSG ch7 header loads with wr_addr starting at 0.
- With LOAD_TIMEOUT_EN: C/A ch2 load stalled after word 5 for 4096 cycles → err pulse, busy low, no done; without macro the block still busy after 10000 cycles and completes when words resume.
